// File: rtl/generic_bus_arbiter_pkg.sv
// bus_arb_pkg: shared state, grant and counter-width definitions for the I/D generic bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;
  localparam int STREAK_W = 4;
endpackage

// File: rtl/generic_bus_arbiter_if.sv
// generic_bus_arbiter_if: I-bus, D-bus and merged memory-side generic bus signals
interface generic_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  localparam int BE_W = DATA_W / 8;
  logic              i_ren, i_wen, i_busy;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata, i_rdata;
  logic [BE_W-1:0]   i_byte_en;
  logic              d_ren, d_wen, d_busy;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [BE_W-1:0]   d_byte_en;
  logic              m_ren, m_wen, m_busy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [BE_W-1:0]   m_byte_en;
  modport slave (
    input  i_ren, i_wen, i_addr, i_wdata, i_byte_en, d_ren, d_wen, d_addr, d_wdata, d_byte_en, m_busy, m_rdata,
    output i_busy, i_rdata, d_busy, d_rdata, m_ren, m_wen, m_addr, m_wdata, m_byte_en
  );
  modport master (
    output i_ren, i_wen, i_addr, i_wdata, i_byte_en, d_ren, d_wen, d_addr, d_wdata, d_byte_en, m_busy, m_rdata,
    input  i_busy, i_rdata, d_busy, d_rdata, m_ren, m_wen, m_addr, m_wdata, m_byte_en
  );
endinterface

// File: rtl/generic_bus_arbiter_mux.sv
// generic_bus_mux: combinational steering of request and response fields for the current grant
module generic_bus_mux
  import bus_arb_pkg::*;
(
  input grant_t                  grant,
  generic_bus_arbiter_if.slave   bus
);
  logic gi, gd;
  assign gi = grant == GNT_I;
  assign gd = grant == GNT_D;
  assign bus.m_ren     = gi ? bus.i_ren     : gd ? bus.d_ren     : 1'b0;
  assign bus.m_wen     = gi ? bus.i_wen     : gd ? bus.d_wen     : 1'b0;
  assign bus.m_addr    = gi ? bus.i_addr    : gd ? bus.d_addr    : '0;
  assign bus.m_wdata   = gi ? bus.i_wdata   : gd ? bus.d_wdata   : '0;
  assign bus.m_byte_en = gi ? bus.i_byte_en : gd ? bus.d_byte_en : '0;
  // The master not holding the grant sees a permanently busy, silent bus
  assign bus.i_busy  = gi ? bus.m_busy  : 1'b1;
  assign bus.d_busy  = gd ? bus.m_busy  : 1'b1;
  assign bus.i_rdata = gi ? bus.m_rdata : '0;
  assign bus.d_rdata = gd ? bus.m_rdata : '0;
endmodule

// File: rtl/generic_bus_arbiter.sv
// generic_bus_arbiter: merges I-bus and D-bus onto one memory port, D priority with I starvation guard
module generic_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  generic_bus_arbiter_if.slave bus
);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);
  arb_state_t          state;
  grant_t              grant;
  logic [STREAK_W-1:0] d_streak;
  logic                i_req, d_req, pick_d;
  assign i_req  = bus.i_ren | bus.i_wen;
  assign d_req  = bus.d_ren | bus.d_wen;
  assign pick_d = d_req && (!i_req || d_streak < LIMIT);
  // Grant is registered with the state so that an async reset drops m_* immediately
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= IDLE;
      grant    <= GNT_NONE;
      d_streak <= '0;
    end else
      case (state)
        IDLE: begin
          state    <= pick_d ? GRANT_D : i_req ? GRANT_I : IDLE;
          grant    <= pick_d ? GNT_D : i_req ? GNT_I : GNT_NONE;
          d_streak <= pick_d ? (i_req ? d_streak + 1'b1 : '0) : i_req ? '0 : d_streak;
        end
        GRANT_I: if (!bus.m_busy || !i_req) begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
        GRANT_D: if (!bus.m_busy || !d_req) begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
        default: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
  generic_bus_mux u_mux (.grant(grant), .bus(bus));
endmodule

// File: tb/tb_generic_bus_arbiter.sv
// tb_generic_bus_arbiter: directed scenario tests for the I/D generic bus arbiter
module tb_generic_bus_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   passed = 0;
  generic_bus_arbiter_if bus ();
  generic_bus_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_ren = 0; bus.i_wen = 0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_byte_en = '0;
    bus.d_ren = 0; bus.d_wen = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_en = '0;
    bus.m_busy = 1; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    cyc();
    cyc();
    RST = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.i_ren = 1; bus.i_addr = 32'h1000; bus.d_ren = 1; bus.d_addr = 32'h2000; bus.m_rdata = 32'h5555AAAA;
    RST = 1;
    cyc(); cyc(); cyc();
    #2;
    total++; if (bus.m_ren !== 1'b0) $display("FAIL rst_m_ren got %b want 0", bus.m_ren); else passed++;
    total++; if (bus.m_wen !== 1'b0) $display("FAIL rst_m_wen got %b want 0", bus.m_wen); else passed++;
    total++; if (bus.m_addr !== 32'h0) $display("FAIL rst_m_addr got %h want 0", bus.m_addr); else passed++;
    total++; if (bus.i_busy !== 1'b1 || bus.d_busy !== 1'b1) $display("FAIL rst_busy got i=%b d=%b want 1 1", bus.i_busy, bus.d_busy); else passed++;
    total++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) $display("FAIL rst_rdata got i=%h d=%h want 0 0", bus.i_rdata, bus.d_rdata); else passed++;
    cyc();
    RST = 0;
    #2;
    total++; if (bus.m_ren !== 1'b0) $display("FAIL rst_release_idle m_ren got %b want 0", bus.m_ren); else passed++;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h2000) $display("FAIL rst_first_grant got ren=%b addr=%h want 1 00002000", bus.m_ren, bus.m_addr); else passed++;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.i_ren = 1; bus.i_addr = 32'h80000000;
    #2;
    total++; if (bus.m_ren !== 1'b0) $display("FAIL rd_c0_m_ren got %b want 0", bus.m_ren); else passed++;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) begin bus.m_busy = 0; bus.m_rdata = 32'hDEADBEEF; end
      #2;
      total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h80000000) $display("FAIL rd_c%0d_m got ren=%b addr=%h want 1 80000000", c, bus.m_ren, bus.m_addr); else passed++;
      total++; if (bus.i_busy !== (c != 3)) $display("FAIL rd_c%0d_i_busy got %b want %b", c, bus.i_busy, c != 3); else passed++;
    end
    total++; if (bus.i_rdata !== 32'hDEADBEEF) $display("FAIL rd_i_rdata got %h want deadbeef", bus.i_rdata); else passed++;
    total++; if (bus.d_busy !== 1'b1 || bus.d_rdata !== 32'h0) $display("FAIL rd_d_side got busy=%b rdata=%h want 1 0", bus.d_busy, bus.d_rdata); else passed++;
    cyc();
    bus.i_ren = 0; bus.m_busy = 1;
    #2;
    total++; if (bus.m_ren !== 1'b0 || bus.i_busy !== 1'b1) $display("FAIL rd_c4 got ren=%b i_busy=%b want 0 1", bus.m_ren, bus.i_busy); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.d_wen = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678; bus.d_byte_en = 4'hF;
    bus.i_ren = 1; bus.i_addr = 32'h200;
    bus.m_busy = 0; bus.m_rdata = 32'hCAFEF00D;
    #2;
    total++; if (bus.m_wen !== 1'b0 || bus.m_ren !== 1'b0) $display("FAIL sim_c0 got ren=%b wen=%b want 0 0", bus.m_ren, bus.m_wen); else passed++;
    cyc();
    #2;
    total++; if (bus.m_wen !== 1'b1 || bus.m_ren !== 1'b0 || bus.m_addr !== 32'h100) $display("FAIL sim_c1_req got ren=%b wen=%b addr=%h want 0 1 00000100", bus.m_ren, bus.m_wen, bus.m_addr); else passed++;
    total++; if (bus.m_wdata !== 32'h12345678 || bus.m_byte_en !== 4'hF) $display("FAIL sim_c1_data got wdata=%h be=%h want 12345678 f", bus.m_wdata, bus.m_byte_en); else passed++;
    total++; if (bus.d_busy !== 1'b0 || bus.i_busy !== 1'b1) $display("FAIL sim_c1_busy got d=%b i=%b want 0 1", bus.d_busy, bus.i_busy); else passed++;
    cyc();
    bus.d_wen = 0;
    #2;
    total++; if (bus.m_ren !== 1'b0 || bus.m_wen !== 1'b0 || bus.m_addr !== 32'h0) $display("FAIL sim_c2_bubble got ren=%b wen=%b addr=%h want 0 0 0", bus.m_ren, bus.m_wen, bus.m_addr); else passed++;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h200) $display("FAIL sim_c3_i got ren=%b addr=%h want 1 00000200", bus.m_ren, bus.m_addr); else passed++;
    total++; if (bus.i_busy !== 1'b0 || bus.i_rdata !== 32'hCAFEF00D) $display("FAIL sim_c3_i_resp got busy=%b rdata=%h want 0 cafef00d", bus.i_busy, bus.i_rdata); else passed++;
    total++; if (bus.d_busy !== 1'b1 || bus.d_rdata !== 32'h0) $display("FAIL sim_c3_d_resp got busy=%b rdata=%h want 1 0", bus.d_busy, bus.d_rdata); else passed++;
    cyc();
    bus.i_ren = 0;
  endtask

  task automatic test_starvation();
    logic        ren_exp;
    logic [31:0] addr_exp;
    do_reset();
    bus.d_ren = 1; bus.d_addr = 32'h300; bus.i_ren = 1; bus.i_addr = 32'h400; bus.m_busy = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      #2;
      ren_exp  = c[0];
      addr_exp = !c[0] ? 32'h0 : (c == 9) ? 32'h400 : 32'h300;
      total++; if (bus.m_ren !== ren_exp || bus.m_addr !== addr_exp) $display("FAIL starve_c%0d got ren=%b addr=%h want %b %h", c, bus.m_ren, bus.m_addr, ren_exp, addr_exp); else passed++;
    end
    bus.d_ren = 0; bus.i_ren = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_ren = 1; bus.d_addr = 32'h500;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h500) $display("FAIL rmid_grant got ren=%b addr=%h want 1 00000500", bus.m_ren, bus.m_addr); else passed++;
    cyc();
    #2;
    RST = 1;
    #1;
    total++; if (bus.m_ren !== 1'b0 || bus.m_addr !== 32'h0) $display("FAIL rmid_async_drop got ren=%b addr=%h want 0 0", bus.m_ren, bus.m_addr); else passed++;
    cyc();
    RST = 0; bus.d_ren = 0; bus.i_ren = 1; bus.i_addr = 32'h600;
    #2;
    total++; if (bus.m_ren !== 1'b0) $display("FAIL rmid_idle got ren=%b want 0", bus.m_ren); else passed++;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h600) $display("FAIL rmid_i_grant got ren=%b addr=%h want 1 00000600", bus.m_ren, bus.m_addr); else passed++;
    bus.i_ren = 0;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.i_ren = 1; bus.i_addr = 32'h700;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h700) $display("FAIL wd_grant got ren=%b addr=%h want 1 00000700", bus.m_ren, bus.m_addr); else passed++;
    cyc();
    bus.i_ren = 0; bus.d_ren = 1; bus.d_addr = 32'h800;
    #2;
    total++; if (bus.i_busy !== 1'b1 || bus.d_busy !== 1'b1) $display("FAIL wd_c2_busy got i=%b d=%b want 1 1", bus.i_busy, bus.d_busy); else passed++;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b0 || bus.i_busy !== 1'b1) $display("FAIL wd_c3_idle got ren=%b i_busy=%b want 0 1", bus.m_ren, bus.i_busy); else passed++;
    cyc();
    #2;
    total++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h800) $display("FAIL wd_c4_d_grant got ren=%b addr=%h want 1 00000800", bus.m_ren, bus.m_addr); else passed++;
    total++; if (bus.i_busy !== 1'b1) $display("FAIL wd_c4_i_busy got %b want 1", bus.i_busy); else passed++;
    bus.d_ren = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_withdraw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/generic_bus_arbiter.md
Name: generic_bus_arbiter

Overview:
- Sits directly downstream of the core's separate I-bus and D-bus generic bus ports and merges them onto one generic bus memory port.
- Used for single-ported memory/interconnect targets.
- Arbitrates per transaction: D-bus has priority, with a starvation guard that guarantees I-bus progress.
- Adds one cycle of arbitration latency per transaction. Data is passed through combinationally while a master is granted.

Parameters:
- STARVE_LIMIT, default 4: max consecutive D grants issued while I is requesting, before I is forced through. Legal range 1..15.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width. byte_en width is DATA_W/8.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- i_ren, i_wen  in  1  I-master read/write request.
- i_addr  in  ADDR_W  I-master address.
- i_wdata  in  DATA_W  I-master write data.
- i_byte_en  in  DATA_W/8  I-master byte enables.
- i_busy  out  1  I-master busy; low for exactly the completion cycle.
- i_rdata  out  DATA_W  I-master read data.
- d_ren, d_wen, d_addr, d_wdata, d_byte_en  in  as I-master  D-master request.
- d_busy, d_rdata  out  as I-master  D-master response.
- m_ren, m_wen  out  1  memory-side request.
- m_addr  out  ADDR_W  memory-side address.
- m_wdata  out  DATA_W  memory-side write data.
- m_byte_en  out  DATA_W/8  memory-side byte enables.
- m_busy  in  1  memory busy; low means the current transfer completes this cycle.
- m_rdata  in  DATA_W  memory read data, valid when m_busy is low.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Bus rule: a master holds ren/wen/addr/wdata/byte_en stable until it sees its busy low. A request is "i_req = i_ren|i_wen" (likewise d_req).
- FSM states: IDLE, GRANT_I, GRANT_D. Reset state is IDLE; d_streak resets to 0.
- Reset values, asynchronous and also the IDLE outputs:
  - m_ren=0, m_wen=0, m_addr=0, m_wdata=0, m_byte_en=0.
  - i_busy=1, d_busy=1.
  - i_rdata=0, d_rdata=0.
- IDLE transitions:
  - d_req only -> GRANT_D.
  - i_req only -> GRANT_I.
  - Both, with d_streak<STARVE_LIMIT -> GRANT_D. Both, with d_streak==STARVE_LIMIT -> GRANT_I.
  - Neither -> stay in IDLE.
- GRANT_x outputs:
  - The granted master's request fields drive m_* combinationally.
  - x_busy = m_busy and x_rdata = m_rdata.
  - The other master sees busy=1 and rdata=0.
- Completion: when m_busy==0 in GRANT_x, the transfer completes that cycle. The next state is IDLE, a mandatory one-cycle bubble.
  - Max throughput is therefore 1 transfer per 2 cycles with a zero-wait slave.
- Request withdrawn while granted (protocol violation): if x_req==0 in GRANT_x, go to IDLE next cycle. No completion is signalled.
- d_streak counter, 4 bits, saturating at STARVE_LIMIT. Updated on the IDLE->grant transition:
  - +1 on a D grant while i_req==1.
  - Cleared to 0 on an I grant.
  - Cleared to 0 when entering GRANT_D with i_req==0.
- ren and wen both asserted by one master: forwarded unchanged. No checking is done.
- Reset mid-transaction: the m_* request drops in the same cycle RST rises (asynchronous). The interrupted transfer is lost and not retried by the arbiter. After RST falls, arbitration restarts from IDLE with d_streak=0.
- Latency: request at cycle n (sampled in IDLE) -> m_* asserted in cycle n+1. The master completes in the first cycle ≥n+1 with m_busy==0.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_t enum {IDLE, GRANT_I, GRANT_D}.
  - grant_t enum {GNT_NONE, GNT_I, GNT_D}.
  - STREAK_W=4 constant.
- One natural sub-module, generic_bus_mux: purely combinational steering of the request and response fields given grant_t. It is instantiated once. The FSM and counter stay in the top.

Test Plan:
- Reset: hold RST=1 with both masters requesting -> m_ren=m_wen=0, i_busy=d_busy=1, i_rdata=d_rdata=0. Drop RST -> m_ren=1 for D one cycle later.
- Single I read: i_ren=1, i_addr=0x80000000 at cycle 0; m_busy low at cycle 3 with m_rdata=0xDEADBEEF -> m_addr=0x80000000 during cycles 1-3; i_busy=0 only in cycle 3 with i_rdata=0xDEADBEEF; m_ren=0 in cycle 4.
- Simultaneous requests: D write (addr 0x100, wdata 0x12345678, byte_en 0xF) and I read at cycle 0, zero-wait slave -> D on m_* in cycle 1, bubble in cycle 2, I on m_* in cycle 3; d_busy=1 throughout I's transfer.
- Starvation, STARVE_LIMIT=4: D requests continuously and I holds its request, zero-wait slave -> D granted 4 times (cycles 1,3,5,7), I granted at cycle 9, D granted again at cycle 11.
- Reset mid-transfer: D read granted with m_busy held high; assert RST mid-cycle -> m_ren falls without a clock edge; after release, pending I-only request granted one cycle later.
- Request withdrawn: I granted, then i_ren drops with m_busy=1 -> IDLE next cycle, no i_busy=0 pulse, D requesting then granted in the following cycle.
